// File: rtl/ripple_adder.sv
// Combinational 64-bit ripple-carry adder; carry-out of the top bit is not produced.
// clk is a legacy port with no function inside the adder.
module ripple_adder (
  input  logic        clk,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic [63:0] sum
);

  logic [63:0] c;
  logic        unused_clk;

  assign unused_clk = clk;
  assign c[0]       = 1'b0;

  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign sum[i] = A[i] ^ B[i] ^ c[i];
    if (i < 63) begin : g_carry
      assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 64x64 shift-add multiplier (low 64 bits), one partial product per cycle via ripple_adder.
// Optional SHIFT_ADD_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc, mcand, mplier, addend, sum;
  logic [5:0]  cnt;
  logic        early_done;

  assign addend = mplier[0] ? mcand : 64'd0;

  ripple_adder u_adder (
    .clk (clk),
    .A   (acc),
    .B   (addend),
    .sum (sum)
  );

`ifdef SHIFT_ADD_EARLY_TERM_EN
  assign early_done = (mplier == 64'd0);
`else
  assign early_done = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (early_done || cnt == 6'd63) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Early termination leaves acc untouched on the terminating edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 64'd0;
      cnt    <= 6'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc    <= 64'd0;
          mcand  <= a;
          mplier <= b;
          cnt    <= 6'd0;
        end
        BUSY: if (!early_done) begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign product   = acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: products, latency, backpressure, reset abort, ignored input.
// Expected latencies select the early-termination column when SHIFT_ADD_EARLY_TERM_EN is defined.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shift_add_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // lat = number of rising edges after the accept edge before out_valid is seen
  task automatic wait_done(output int lat);
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  function automatic int pick_lat(input int lat_full, input int lat_et);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    return lat_et;
`else
    return lat_full;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int lat_full, input int lat_et);
    int lat;
    out_ready = 1'b1;
    start_op(x, y);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(pick_lat(lat_full, lat_et)));
    check({tag, " product"}, product, exp);
    check({tag, " busy low in done"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    check({tag, " idle after consume"}, {63'd0, in_ready}, 64'd1);
    check({tag, " out_valid cleared"}, {63'd0, out_valid}, 64'd0);
  endtask

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] p;
    int          lf;
    int          le;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          lat;
    int          seen;
    logic [63:0] held;

    vecs[0] = '{64'd3, 64'd5, 64'd15, 64, 4};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64, 3};
    vecs[2] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64, 34};
    vecs[3] = '{64'h1234, 64'd0, 64'd0, 64, 1};
    vecs[4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64, 64};
    vecs[5] = '{64'd3, 64'h80, 64'h180, 64, 9};
    vecs[6] = '{64'h1_0000_0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64, 33};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 64'd0;
    b         = 64'd0;
    out_ready = 1'b1;
    #1;
    check("reset product", product, 64'd0);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].p, vecs[i].lf, vecs[i].le);

    // Backpressure: hold out_ready low, present a competing request meanwhile
    out_ready = 1'b0;
    start_op(64'd9, 64'd11);
    @(negedge clk);
    check("bp busy after accept", {63'd0, busy}, 64'd1);
    wait_done(lat);
    check("bp latency", 64'(lat + 1), 64'(pick_lat(64, 5)));
    held     = product;
    in_valid = 1'b1;
    a        = 64'd2;
    b        = 64'd2;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp out_valid %0d", k), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp product %0d", k), product, 64'd99);
      check($sformatf("bp in_ready %0d", k), {63'd0, in_ready}, 64'd0);
    end
    check("bp held value", held, 64'd99);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp idle after consume", {63'd0, in_ready}, 64'd1);
    check("bp no accept on consume", {63'd0, busy}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp still idle", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of an operation
    start_op(64'd5, 64'h8000_0000_0000_0001);
    repeat (30) @(negedge clk);
    check("abort busy before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort out_valid", {63'd0, out_valid}, 64'd0);
    check("abort product", product, 64'd0);
    check("abort in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after abort", 64'd7, 64'd9, 64'd63, 64, 5);

    // in_valid toggling during BUSY must not start another operation
    out_ready = 1'b1;
    start_op(64'd6, 64'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = (k != 1);
      a        = 64'd1;
      b        = 64'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    check("ignored product", product, 64'd42);
    check("ignored out_valid", {63'd0, out_valid}, 64'd1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no second result", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
